flops_pipe: RTL and testbench
=============================

Name: flops_pipe

Overview:
- Parametrised successor to the single-stage 32-bit valid/data register used on the PHY RX path.
- Builds a DEPTH-stage register pipeline of WIDTH-bit data with valid/ready backpressure and bubble collapse.
- Adds a synchronous flush and an occupancy count.
- Sits between PHY RX datapath blocks wherever retiming or elastic slack is needed.

Parameters:
- WIDTH, 32, data bus width in bits (>=1).
- DEPTH, 2, number of register stages (>=1).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clk_Flops  input  1  single clock, rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- flush_Flops  input  1  synchronous clear of all stages.
- valid_in_Flops  input  1  upstream word valid.
- data_in_Flops  input  WIDTH  upstream word.
- ready_in_Flops  output  1  block can accept a word this cycle.
- valid_out_Flops  output  1  last stage holds a valid word.
- data_out_Flops  output  WIDTH  last-stage word.
- ready_out_Flops  input  1  downstream accepts a word this cycle.
- count_Flops  output  CNT_W  number of occupied stages.

Behaviour:
- Reset: reset_L low asynchronously clears every stage (valid=0, data=0). valid_out_Flops=0, data_out_Flops=0, count_Flops=0. ready_in_Flops=1 once reset releases.
- Stage i holds v[i] and d[i]. Stage 0 is the input and stage DEPTH-1 drives the outputs directly (registered outputs).
- Ready chain:
  - r[DEPTH] = ready_out_Flops.
  - r[i] = !v[i] | r[i+1].
  - ready_in_Flops = r[0] & !flush_Flops.
  - This is a combinational path from ready_out_Flops to ready_in_Flops.
- Stage i updates only when r[i]=1:
  - v[i] <= v[i-1] and d[i] <= d[i-1] (for stage 0, the inputs are used).
  - If the loaded valid is 0, d[i] <= 0. Invalid stages always hold zero data.
- Transfers:
  - Upstream transfer: valid_in_Flops & ready_in_Flops.
  - Downstream transfer: valid_out_Flops & ready_out_Flops.
- Latency and throughput:
  - DEPTH cycles from input to output when there is no stall.
  - One word per cycle sustained while ready_out_Flops=1.
- Bubble collapse: an empty stage accepts from the stage behind it even while a later stage is stalled. A full pipeline holds DEPTH words with ready_out_Flops=0.
- Full: all v=1 and ready_out_Flops=0 gives ready_in_Flops=0. Data is held stable and no word is lost or duplicated.
- Full with ready_out_Flops=1: ready_in_Flops=1 in the same cycle. The pipeline shifts and accepts simultaneously.
- Empty: valid_out_Flops=0 and data_out_Flops=0, regardless of ready_out_Flops.
- Flush:
  - flush_Flops=1 at a clock edge clears all v and d to 0. Flush has priority over any shift.
  - ready_in_Flops=0 during the flush cycle, so no upstream word is consumed.
  - A downstream transfer presented in that cycle still completes; the stage is cleared after it.
- count_Flops: registered popcount of v[]. Range 0..DEPTH, no wrap. It reads 0 the cycle after a flush or reset.
- Reset mid-operation: in-flight words are discarded, with no partial output.
- With valid_in_Flops=0, data_in_Flops is ignored.

Decomposition:
- Shared package (phy_rx_pkg) holds the default WIDTH (32) and default DEPTH constants.
- One natural sub-module: flops_stage, a single valid/data register slice with load enable, zero-on-invalid and flush. It is instantiated DEPTH times in a generate loop, with the ready chain and popcount in the top level.

Test Plan:
- Reset: WIDTH=32, DEPTH=3, reset_L low with valid_in=1 and data_in=32'hDEADBEEF -> valid_out=0, data_out=0, count=0, and all three stay at those values until reset release.
- Streaming: ready_out=1, send 32'h1, 32'h2, 32'h3 on consecutive cycles -> the same values appear on data_out 3 cycles later, in order, with valid_out=1; count peaks at 3.
- Backpressure: ready_out=0, push 4 words A1..A4 -> A1..A3 are accepted, ready_in=0 on the 4th attempt, count=3, data_out=A1 stable. Raise ready_out -> A1, A2, A3 drain in order with no duplicates.
- Bubble collapse: load word 32'h55 into stage 0 only, hold ready_out=0 -> 32'h55 reaches the last stage after 2 more cycles, and ready_in stays 1 until count=3.
- Flush: with 3 words held, assert flush for 1 cycle while valid_in=1 and data_in=32'h77 -> ready_in=0 that cycle, the next cycle count=0 and valid_out=0, and 32'h77 never appears at the output.
- Async reset mid-stream: drop reset_L between clock edges with 2 words in flight -> outputs clear immediately, without waiting for a clock edge, and nothing is emitted after release.

Source files
------------

// File: rtl/phy_rx_pkg.sv
// Shared constants for the PHY RX datapath blocks.
// Holds the default data width and the default retiming depth used by flops_pipe.
package phy_rx_pkg;

  localparam int unsigned PhyRxWidth = 32;
  localparam int unsigned PhyRxDepth = 2;

endpackage

// File: rtl/flops_stage.sv
// Single valid/data register slice of the flops_pipe pipeline.
// Ports:
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   flush_i         synchronous clear; overrides load_i
//   load_i          take valid_i/data_i at the next edge
//   valid_i/data_i  word from the stage behind (or from upstream)
//   valid_o/data_o  registered slice contents
//   valid_d_o       next-state valid, used for the registered occupancy count
module flops_stage
  import phy_rx_pkg::*;
#(
  parameter int unsigned Width = PhyRxWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             valid_d_o
);

  logic             valid_d, valid_q;
  logic [Width-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = valid_i;
      // An empty slice always carries zero data.
      data_d  = valid_i ? data_i : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign valid_d_o = valid_d;

endmodule

// File: rtl/flops_pipe.sv
// DEPTH-stage valid/ready register pipeline with bubble collapse, flush and occupancy count.
// Ports:
//   clk_Flops, reset_L               clock and asynchronous active-low reset
//   flush_Flops                      synchronous clear of all stages
//   valid_in_Flops, data_in_Flops    upstream word; ready_in_Flops back to upstream
//   valid_out_Flops, data_out_Flops  last-stage word; ready_out_Flops from downstream
//   count_Flops                      registered number of occupied stages
module flops_pipe
  import phy_rx_pkg::*;
#(
  parameter int unsigned WIDTH = PhyRxWidth,
  parameter int unsigned DEPTH = PhyRxDepth,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_Flops,
  input  logic             reset_L,
  input  logic             flush_Flops,
  input  logic             valid_in_Flops,
  input  logic [WIDTH-1:0] data_in_Flops,
  output logic             ready_in_Flops,
  output logic             valid_out_Flops,
  output logic [WIDTH-1:0] data_out_Flops,
  input  logic             ready_out_Flops,
  output logic [CNT_W-1:0] count_Flops
);

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_d;
  logic [DEPTH-1:0] src_vld;
  logic [WIDTH-1:0] dat     [DEPTH];
  logic [WIDTH-1:0] src_dat [DEPTH];
  logic [CNT_W-1:0] count_d, count_q;

  // A stage can load when it is empty or the stage ahead of it is moving;
  // this lets bubbles collapse behind a stalled output.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = ready_out_Flops;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      rdy[i] = ~vld[i] | rdy[i+1];
    end
  end

  assign ready_in_Flops = rdy[0] & ~flush_Flops;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign src_vld[g] = valid_in_Flops;
      assign src_dat[g] = data_in_Flops;
    end else begin : g_body
      assign src_vld[g] = vld[g-1];
      assign src_dat[g] = dat[g-1];
    end

    flops_stage #(
      .Width(WIDTH)
    ) u_stage (
      .clk_i    (clk_Flops),
      .rst_ni   (reset_L),
      .flush_i  (flush_Flops),
      .load_i   (rdy[g]),
      .valid_i  (src_vld[g]),
      .data_i   (src_dat[g]),
      .valid_o  (vld[g]),
      .data_o   (dat[g]),
      .valid_d_o(vld_d[g])
    );
  end

  // Count is the popcount of the next-state valids so it lines up with the stage registers.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      count_d = count_d + CNT_W'(vld_d[i]);
    end
  end

  always_ff @(posedge clk_Flops or negedge reset_L) begin
    if (!reset_L) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign valid_out_Flops = vld[DEPTH-1];
  assign data_out_Flops  = dat[DEPTH-1];
  assign count_Flops     = count_q;

endmodule

// File: tb/tb_flops_pipe.sv
// Self-checking bench for flops_pipe (WIDTH=32, DEPTH=3): directed scenarios plus random
// traffic, with a word-order scoreboard and an occupancy model checked every cycle.
module tb_flops_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 3;
  localparam int unsigned CW = $clog2(D + 1);

  logic          clk;
  logic          reset_l;
  logic          flush;
  logic          valid_in;
  logic [W-1:0]  data_in;
  logic          ready_in;
  logic          valid_out;
  logic [W-1:0]  data_out;
  logic          ready_out;
  logic [CW-1:0] count;

  flops_pipe #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk_Flops      (clk),
    .reset_L        (reset_l),
    .flush_Flops    (flush),
    .valid_in_Flops (valid_in),
    .data_in_Flops  (data_in),
    .ready_in_Flops (ready_in),
    .valid_out_Flops(valid_out),
    .data_out_Flops (data_out),
    .ready_out_Flops(ready_out),
    .count_Flops    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb_q[$];
  int exp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change at negedge+1; an accepted word is logged at negedge+3, before the edge.
  task automatic drive(input bit v, input logic [W-1:0] d, input bit ro, input bit fl);
    @(negedge clk);
    #1;
    valid_in  = v;
    data_in   = d;
    ready_out = ro;
    flush     = fl;
    #2;
    if (v && ready_in && reset_l) sb_q.push_back(d);
  endtask

  task automatic idle(input bit ro, input int n);
    for (int k = 0; k < n; k++) drive(1'b0, '0, ro, 1'b0);
  endtask

  // Monitor: samples at negedge+4 and models the coming clock edge.
  initial begin
    bit up, dn;
    forever begin
      @(negedge clk);
      #4;
      if (!reset_l) begin
        check("rst_valid_out", valid_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_count", count, 0);
        sb_q.delete();
        exp_cnt = 0;
      end else begin
        check("count", count, exp_cnt);
        check("ready_in", ready_in, !((exp_cnt == D) && !ready_out) && !flush);
        if (exp_cnt == 0) begin
          check("empty_valid_out", valid_out, 0);
          check("empty_data_out", data_out, 0);
        end
        up = valid_in && ready_in;
        dn = valid_out && ready_out;
        if (dn) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %0h expected none", data_out);
          end else begin
            check("data_out", data_out, sb_q.pop_front());
          end
        end
        if (flush) begin
          sb_q.delete();
          exp_cnt = 0;
        end else begin
          exp_cnt = exp_cnt + int'(up) - int'(dn);
        end
      end
    end
  end

  initial begin
    reset_l   = 1'b0;
    flush     = 1'b0;
    valid_in  = 1'b1;
    data_in   = 32'hDEADBEEF;
    ready_out = 1'b1;

    // Reset holds outputs at zero despite an offered word.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #2;
      check("reset_hold_valid", valid_out, 0);
      check("reset_hold_data", data_out, 0);
      check("reset_hold_count", count, 0);
    end
    valid_in = 1'b0;
    data_in  = '0;
    reset_l  = 1'b1;
    #1;
    check("ready_after_reset", ready_in, 1);

    // Streaming: three-cycle latency, in-order, count peaks at 3.
    drive(1'b1, 32'h1, 1'b1, 1'b0);
    drive(1'b1, 32'h2, 1'b1, 1'b0);
    drive(1'b1, 32'h3, 1'b1, 1'b0);
    check("stream_not_early", valid_out, 0);
    idle(1'b1, 1);
    check("stream_count_peak", count, 3);
    check("stream_w1_valid", valid_out, 1);
    check("stream_w1", data_out, 32'h1);
    idle(1'b1, 1);
    check("stream_w2", data_out, 32'h2);
    idle(1'b1, 1);
    check("stream_w3", data_out, 32'h3);
    idle(1'b1, 3);

    // Backpressure: three words fill the pipe, the fourth is refused.
    drive(1'b1, 32'hA1, 1'b0, 1'b0);
    drive(1'b1, 32'hA2, 1'b0, 1'b0);
    drive(1'b1, 32'hA3, 1'b0, 1'b0);
    drive(1'b1, 32'hA4, 1'b0, 1'b0);
    check("bp_ready_full", ready_in, 0);
    check("bp_count_full", count, 3);
    check("bp_head", data_out, 32'hA1);
    idle(1'b0, 1);
    check("bp_head_stable", data_out, 32'hA1);
    idle(1'b1, 1);
    check("bp_drain1", data_out, 32'hA1);
    idle(1'b1, 1);
    check("bp_drain2", data_out, 32'hA2);
    idle(1'b1, 1);
    check("bp_drain3", data_out, 32'hA3);
    idle(1'b1, 3);

    // Bubble collapse: a lone word walks to the last stage while the output stalls.
    drive(1'b1, 32'h55, 1'b0, 1'b0);
    idle(1'b0, 1);
    check("bub_count1", count, 1);
    check("bub_not_yet", valid_out, 0);
    check("bub_ready1", ready_in, 1);
    idle(1'b0, 1);
    check("bub_ready2", ready_in, 1);
    check("bub_not_yet2", valid_out, 0);
    drive(1'b1, 32'h66, 1'b0, 1'b0);
    check("bub_arrived_valid", valid_out, 1);
    check("bub_arrived_data", data_out, 32'h55);
    drive(1'b1, 32'h67, 1'b0, 1'b0);
    check("bub_ready_before_full", ready_in, 1);
    idle(1'b0, 1);
    check("bub_full_count", count, 3);
    check("bub_full_ready", ready_in, 0);

    // Flush with three words held and an offered word.
    drive(1'b1, 32'h77, 1'b0, 1'b1);
    check("flush_ready_low", ready_in, 0);
    idle(1'b0, 1);
    check("flush_count", count, 0);
    check("flush_valid_out", valid_out, 0);
    idle(1'b1, 4);

    // Asynchronous reset with two words in flight.
    drive(1'b1, 32'hB0, 1'b1, 1'b0);
    drive(1'b1, 32'hB1, 1'b1, 1'b0);
    idle(1'b1, 1);
    @(posedge clk);
    #2;
    check("areset_pre_valid", valid_out, 1);
    reset_l = 1'b0;
    #1;
    check("areset_valid", valid_out, 0);
    check("areset_data", data_out, 0);
    check("areset_count", count, 0);
    for (int k = 0; k < 2; k++) @(negedge clk);
    #2;
    reset_l = 1'b1;
    idle(1'b1, 5);
    check("areset_nothing_after", valid_out, 0);

    // Random traffic including occasional flushes.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 99) < 70), $urandom, 1'($urandom_range(0, 99) < 60),
            1'($urandom_range(0, 29) == 0));
    end
    idle(1'b1, 6);
    check("final_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
